key_encoder: RTL and testbench

- Reverse direction of the board's switch-to-LED decoder path.
- Takes 8 active-low key lines (idle 8'hff, one line pulled low per pressed key) and produces the 3-bit key code plus an enable word in the decoder's encoding (3'd4 = enabled).
- The key lines are synchronised and debounced, then priority-encoded.
- Press/release strobes are generated for downstream logic.
- Sits between the board key pins and any consumer of (switch, enable) pairs.

---
 rtl/key_encoder_if.sv | 21 ++
 rtl/key_encoder.sv | 96 +++++++++
 tb/tb_key_encoder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/key_encoder_if.sv
// Key-pin bundle: raw active-low key lines in; the debounced (code, enable) pair and strobes out.
// The release strobe is named release_p because "release" is a reserved word.
interface key_encoder_if;
    logic [7:0] keys_n;
    logic [2:0] code;
    logic [2:0] enable;
    logic       valid;
    logic       multi;
    logic       press;
    logic       release_p;

    modport master (
        output keys_n,
        input  code, enable, valid, multi, press, release_p
    );

    modport slave (
        input  keys_n,
        output code, enable, valid, multi, press, release_p
    );
endinterface

// File: rtl/key_encoder.sv
// Synchronises and debounces eight active-low key lines, then priority-encodes the
// stable vector into a key code, a decoder-style enable word and press/release strobes.
module key_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    key_encoder_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       ENABLED  = 3'd4;

    logic [7:0]       sync1_q, s_q;
    logic [7:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       stable_q, stable_d;
    logic [2:0]       code_q, code_d;
    logic [2:0]       enable_q, enable_d;
    logic             valid_q, valid_d;
    logic             multi_q, multi_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [3:0]       zeros;

    // The debounce counter saturates so a long-held vector is never re-committed.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (s_q != cand_q) begin
            cand_d = s_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q == CNT_LAST) begin
                stable_d = cand_q;
            end
        end
    end

    // Descending scan so the lowest-numbered pressed key wins; code holds when idle.
    always_comb begin
        zeros  = 4'd0;
        code_d = code_q;
        for (int i = 7; i >= 0; i--) begin
            zeros = zeros + {3'b000, ~stable_q[i]};
            if (!stable_q[i]) begin
                code_d = 3'(i);
            end
        end
        valid_d   = (stable_q != 8'hff);
        multi_d   = (zeros > 4'd1);
        enable_d  = (valid_d && !multi_d) ? ENABLED : 3'd0;
        press_d   = valid_d && !valid_q;
        release_d = !valid_d && valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 8'hff;
            s_q       <= 8'hff;
            cand_q    <= 8'hff;
            cnt_q     <= '0;
            stable_q  <= 8'hff;
            code_q    <= 3'd0;
            enable_q  <= 3'd0;
            valid_q   <= 1'b0;
            multi_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= bus.keys_n;
            s_q       <= sync1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            code_q    <= code_d;
            enable_q  <= enable_d;
            valid_q   <= valid_d;
            multi_q   <= multi_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign bus.code      = code_q;
    assign bus.enable    = enable_q;
    assign bus.valid     = valid_q;
    assign bus.multi     = multi_q;
    assign bus.press     = press_q;
    assign bus.release_p = release_q;
endmodule

// File: tb/tb_key_encoder.sv
// Directed and randomised stimulus for key_encoder, checked every cycle against a
// sample-history reference model of the synchroniser, debouncer and encoder.
module tb_key_encoder;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    key_encoder_if bus();

    key_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: raw samples, synchronised samples, accepted vector, outputs.
    logic [7:0] raw_q[$];
    logic [7:0] s_hist[$];
    logic [7:0] st_m;
    logic [2:0] m_code, m_enable;
    logic       m_valid, m_multi, m_press, m_rel;

    function automatic void model_reset();
        raw_q.delete();
        raw_q.push_back(8'hff);
        raw_q.push_back(8'hff);
        s_hist.delete();
        s_hist.push_back(8'hff);
        st_m     = 8'hff;
        m_code   = 3'd0;
        m_enable = 3'd0;
        m_valid  = 1'b0;
        m_multi  = 1'b0;
        m_press  = 1'b0;
        m_rel    = 1'b0;
    endfunction

    // One rising edge of the model with key vector k present at that edge.
    function automatic void model_edge(input logic [7:0] k);
        logic [7:0] s;
        int         nz;
        bit         v_new;
        bit         same;
        raw_q.push_back(k);
        s = raw_q[raw_q.size() - 3];
        while (raw_q.size() > 3) void'(raw_q.pop_front());

        nz    = 0;
        v_new = (st_m != 8'hff);
        for (int i = 0; i < 8; i++) if (st_m[i] == 1'b0) nz++;
        if (v_new) begin
            for (int i = 7; i >= 0; i--) if (st_m[i] == 1'b0) m_code = 3'(i);
        end
        m_multi  = (nz > 1);
        m_enable = (v_new && !m_multi) ? 3'd4 : 3'd0;
        m_press  = v_new && !m_valid;
        m_rel    = !v_new && m_valid;
        m_valid  = v_new;

        // A vector is accepted once D+1 consecutive synchronised samples agree.
        s_hist.push_back(s);
        while (s_hist.size() > D + 1) void'(s_hist.pop_front());
        if (s_hist.size() == D + 1) begin
            same = 1'b1;
            foreach (s_hist[i]) if (s_hist[i] != s) same = 1'b0;
            if (same) st_m = s;
        end
    endfunction

    task automatic tick(input string tag);
        logic [10:0] got, exp;
        model_edge(bus.keys_n);
        @(posedge clk);
        #1;
        got = {bus.code, bus.enable, bus.valid, bus.multi, bus.press, bus.release_p};
        exp = {m_code, m_enable, m_valid, m_multi, m_press, m_rel};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got code/en/v/m/p/r=%h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Holds the current keys for n edges and reports the first press/release edge index.
    task automatic run_watch(input string tag, input int n, output int p_at, output int r_at);
        p_at = -1;
        r_at = -1;
        for (int i = 1; i <= n; i++) begin
            tick(tag);
            if (bus.press === 1'b1 && p_at < 0) p_at = i;
            if (bus.release_p === 1'b1 && r_at < 0) r_at = i;
        end
    endtask

    initial begin
        int p_at, r_at, p2, r2, sel, dur;
        logic [7:0] kv;

        bus.keys_n = 8'hff;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert ({bus.code, bus.enable, bus.valid, bus.multi, bus.press, bus.release_p} === 11'd0) else begin
            errors++;
            $error("FAIL reset_state: got %h expected 0",
                   {bus.code, bus.enable, bus.valid, bus.multi, bus.press, bus.release_p});
        end
        rst_n = 1'b1;

        // Idle
        run_watch("idle", 50, p_at, r_at);
        check_int("idle_no_press", p_at, -1);

        // Single press latency
        bus.keys_n = 8'hfb;
        run_watch("single_press", 12, p_at, r_at);
        check_int("press_latency", p_at, D + 4);
        check_int("press_code", int'(bus.code), 2);
        check_int("press_enable", int'(bus.enable), 4);

        // Release keeps the code
        bus.keys_n = 8'hff;
        run_watch("release", 12, p_at, r_at);
        check_int("release_latency", r_at, D + 4);
        check_int("release_code_hold", int'(bus.code), 2);

        // Short glitch rejected
        bus.keys_n = 8'hef;
        run_watch("glitch3", 3, p_at, r_at);
        bus.keys_n = 8'hff;
        run_watch("glitch3_after", 15, p2, r2);
        check_int("glitch3_no_press", (p_at < 0 && p2 < 0) ? 1 : 0, 1);

        // Five-cycle pulse accepted
        bus.keys_n = 8'hef;
        run_watch("glitch5", 5, p_at, r_at);
        bus.keys_n = 8'hff;
        run_watch("glitch5_after", 15, p2, r2);
        check_int("glitch5_press_at", p2 + 5, D + 4);
        check_int("glitch5_release_gap", r2 - p2, 5);

        // Multi-key then direct change to single key
        bus.keys_n = 8'h5f;
        run_watch("multi", 12, p_at, r_at);
        check_int("multi_code", int'(bus.code), 5);
        check_int("multi_flag", int'(bus.multi), 1);
        bus.keys_n = 8'h7f;
        run_watch("multi_to_single", 12, p_at, r_at);
        check_int("m2s_no_pulse", (p_at < 0 && r_at < 0) ? 1 : 0, 1);
        check_int("m2s_enable", int'(bus.enable), 4);

        // Asynchronous reset mid-press
        bus.keys_n = 8'hfb;
        run_watch("pre_reset", 12, p_at, r_at);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        assert ({bus.code, bus.enable, bus.valid, bus.multi, bus.press, bus.release_p} === 11'd0) else begin
            errors++;
            $error("FAIL async_reset_clear: got %h expected 0",
                   {bus.code, bus.enable, bus.valid, bus.multi, bus.press, bus.release_p});
        end
        bus.keys_n = 8'hfe;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_watch("post_reset", 12, p_at, r_at);
        check_int("post_reset_press_at", p_at, D + 4);
        check_int("post_reset_code", int'(bus.code), 0);

        // Randomised segments
        for (int seg = 0; seg < 250; seg++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 3)      kv = 8'hff;
            else if (sel < 7) kv = ~(8'h01 << $urandom_range(0, 7));
            else              kv = 8'($urandom());
            dur = int'($urandom_range(1, 12));
            bus.keys_n = kv;
            for (int c = 0; c < dur; c++) tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
